// File: rtl/fifo_cmd_reader.sv
// Pulls register commands from a FIFO with registered read data into a 2-entry skid buffer.
// Optional feature: define FIFO_CMD_READER_STATS_EN to build the accepted-command counter.
module fifo_cmd_reader #(
  parameter int unsigned WIDTH     = 72,
  parameter int unsigned ADDR_BITS = 7,
  parameter int unsigned DATA_BITS = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_rd_data,
  input  logic                 fifo_rd_empty,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic                 cmd_rw,
  output logic [ADDR_BITS-1:0] cmd_addr,
  output logic [DATA_BITS-1:0] cmd_data,
  output logic [15:0]          cmd_count,
  output logic                 busy
);

  logic [WIDTH-1:0] buf_q [2];
  logic [1:0]       occ_q, occ_d;
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic             inflight_q;
  logic             push, pop;
  logic [2:0]       fill;
  logic [WIDTH-1:0] head_entry;

  // Credit check uses pre-pop occupancy, so a slot freed this cycle is reused next cycle.
  assign fill       = {1'b0, occ_q} + {2'b00, inflight_q};
  assign fifo_rd_en = rst_n & enable & ~fifo_rd_empty & (fill < 3'd2);

  assign push      = inflight_q;
  assign cmd_valid = (occ_q != 2'd0);
  assign pop       = cmd_valid & cmd_ready;
  assign busy      = inflight_q | cmd_valid;

  assign head_entry = buf_q[head_q];
  assign cmd_rw     = head_entry[WIDTH-1];
  assign cmd_addr   = head_entry[WIDTH-2 -: ADDR_BITS];
  assign cmd_data   = head_entry[DATA_BITS-1:0];

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    if (push) tail_d = ~tail_q;
    if (pop)  head_d = ~head_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= 2'd0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      inflight_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      inflight_q <= fifo_rd_en;
    end
  end

  // Storage needs no reset; occupancy alone qualifies its contents.
  always_ff @(posedge clk) begin
    if (push) buf_q[tail_q] <= fifo_rd_data;
  end

`ifdef FIFO_CMD_READER_STATS_EN
  logic [15:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 16'd0;
    end else if (pop) begin
      count_q <= count_q + 16'd1;
    end
  end

  assign cmd_count = count_q;
`else
  assign cmd_count = 16'd0;
`endif

endmodule
